// File: rtl/id_stage.sv
// RV32I decode stage: IF/ID latch, register file, decoder, hazard unit, beq/bne resolver, ID/EX register.
// Define ID_STALL_CNT_EN to add the stall_cnt / flush_cnt performance counters.
module id_stage #(
   parameter logic [31:0] NOP_INSTR = 32'h00000013,
   parameter logic [31:0] RESET_PC  = 32'h00000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] if_pc,
   input  logic [31:0] if_instr,
   input  logic        mem_reg_write,
   input  logic        mem_mem_read,
   input  logic [4:0]  mem_rd,
   input  logic [31:0] mem_alu_result,
   input  logic        wb_reg_write,
   input  logic [4:0]  wb_rd,
   input  logic [31:0] wb_data,
   output logic        stall,
   output logic        branch_taken,
   output logic [31:0] branch_target,
   output logic [31:0] ex_pc,
   output logic [31:0] ex_rs1_data,
   output logic [31:0] ex_rs2_data,
   output logic [31:0] ex_imm,
   output logic [4:0]  ex_rs1,
   output logic [4:0]  ex_rs2,
   output logic [4:0]  ex_rd,
   output logic [3:0]  ex_alu_ctrl,
   output logic        ex_alu_src,
   output logic        ex_reg_write,
   output logic        ex_mem_read,
   output logic        ex_mem_write
`ifdef ID_STALL_CNT_EN
   ,
   output logic [31:0] stall_cnt,
   output logic [31:0] flush_cnt
`endif
);

   localparam logic [6:0] OP_R      = 7'h33;
   localparam logic [6:0] OP_I      = 7'h13;
   localparam logic [6:0] OP_LOAD   = 7'h03;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_BRANCH = 7'h63;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] rs1_data;
      logic [31:0] rs2_data;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [3:0]  alu_ctrl;
      logic        alu_src;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
   } idex_t;

   logic [31:0] instr_q, instr_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] rf_q [32];
   idex_t       idex_q, idex_d;

   logic [6:0]  opcode;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  funct3;
   logic        funct7_b5;
   logic [31:0] imm_i, imm_s, imm_b;
   logic        is_r, is_i, is_load, is_store, is_branch;
   logic        use_rs1, use_rs2;
   logic [31:0] rs1_rf, rs2_rf;
   logic [31:0] cmp_a, cmp_b;
   logic        br_cond;
   logic        load_use, br_ex_hazard, br_mem_hazard;

   assign opcode    = instr_q[6:0];
   assign rd        = instr_q[11:7];
   assign funct3    = instr_q[14:12];
   assign rs1       = instr_q[19:15];
   assign rs2       = instr_q[24:20];
   assign funct7_b5 = instr_q[30];

   assign imm_i = {{20{instr_q[31]}}, instr_q[31:20]};
   assign imm_s = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
   assign imm_b = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};

   assign is_r      = (opcode == OP_R);
   assign is_i      = (opcode == OP_I);
   assign is_load   = (opcode == OP_LOAD);
   assign is_store  = (opcode == OP_STORE);
   assign is_branch = (opcode == OP_BRANCH);
   assign use_rs1   = is_r | is_i | is_load | is_store | is_branch;
   assign use_rs2   = is_r | is_store | is_branch;

   // Register reads see this cycle's writeback so WB never needs a separate forward into ID.
   assign rs1_rf = (rs1 == 5'd0) ? 32'd0 :
                   (wb_reg_write && (wb_rd == rs1)) ? wb_data : rf_q[rs1];
   assign rs2_rf = (rs2 == 5'd0) ? 32'd0 :
                   (wb_reg_write && (wb_rd == rs2)) ? wb_data : rf_q[rs2];

   assign cmp_a = (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == rs1)) ? mem_alu_result : rs1_rf;
   assign cmp_b = (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == rs2)) ? mem_alu_result : rs2_rf;

   always_comb begin
      br_cond = 1'b0;
      case (funct3)
         3'b000:  br_cond = (cmp_a == cmp_b);
         3'b001:  br_cond = (cmp_a != cmp_b);
         default: br_cond = 1'b0;
      endcase
   end

   assign load_use = idex_q.mem_read && (idex_q.rd != 5'd0) &&
                     ((use_rs1 && (idex_q.rd == rs1)) || (use_rs2 && (idex_q.rd == rs2)));
   assign br_ex_hazard = is_branch && idex_q.reg_write && (idex_q.rd != 5'd0) &&
                         ((idex_q.rd == rs1) || (idex_q.rd == rs2));
   assign br_mem_hazard = is_branch && mem_mem_read && (mem_rd != 5'd0) &&
                          ((mem_rd == rs1) || (mem_rd == rs2));

   assign stall         = load_use | br_ex_hazard | br_mem_hazard;
   assign branch_taken  = is_branch & br_cond & ~stall;
   assign branch_target = pc_q + imm_b;

   always_comb begin
      instr_d = instr_q;
      pc_d    = pc_q;
      if (branch_taken) begin
         instr_d = NOP_INSTR;
         pc_d    = RESET_PC;
      end else if (!stall) begin
         instr_d = if_instr;
         pc_d    = if_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         instr_q <= NOP_INSTR;
         pc_q    <= RESET_PC;
      end else begin
         instr_q <= instr_d;
         pc_q    <= pc_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wb_reg_write && (wb_rd != 5'd0)) begin
         rf_q[wb_rd] <= wb_data;
      end
   end

   // Branches, unknown opcodes, stalls and taken branches all leave an all-zero bubble in ID/EX.
   always_comb begin
      idex_d = '0;
      if (!stall && !branch_taken) begin
         case (opcode)
            OP_R: begin
               idex_d.pc        = pc_q;
               idex_d.rs1       = rs1;
               idex_d.rs2       = rs2;
               idex_d.rs1_data  = rs1_rf;
               idex_d.rs2_data  = rs2_rf;
               idex_d.rd        = rd;
               idex_d.alu_ctrl  = {funct7_b5, funct3};
               idex_d.reg_write = 1'b1;
            end
            OP_I: begin
               idex_d.pc        = pc_q;
               idex_d.rs1       = rs1;
               idex_d.rs1_data  = rs1_rf;
               idex_d.imm       = imm_i;
               idex_d.rd        = rd;
               idex_d.alu_ctrl  = {(funct3 == 3'b101) & funct7_b5, funct3};
               idex_d.alu_src   = 1'b1;
               idex_d.reg_write = 1'b1;
            end
            OP_LOAD: begin
               idex_d.pc        = pc_q;
               idex_d.rs1       = rs1;
               idex_d.rs1_data  = rs1_rf;
               idex_d.imm       = imm_i;
               idex_d.rd        = rd;
               idex_d.alu_src   = 1'b1;
               idex_d.reg_write = 1'b1;
               idex_d.mem_read  = 1'b1;
            end
            OP_STORE: begin
               idex_d.pc        = pc_q;
               idex_d.rs1       = rs1;
               idex_d.rs2       = rs2;
               idex_d.rs1_data  = rs1_rf;
               idex_d.rs2_data  = rs2_rf;
               idex_d.imm       = imm_s;
               idex_d.alu_src   = 1'b1;
               idex_d.mem_write = 1'b1;
            end
            default: idex_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idex_q <= '0;
      end else begin
         idex_q <= idex_d;
      end
   end

   assign ex_pc        = idex_q.pc;
   assign ex_rs1_data  = idex_q.rs1_data;
   assign ex_rs2_data  = idex_q.rs2_data;
   assign ex_imm       = idex_q.imm;
   assign ex_rs1       = idex_q.rs1;
   assign ex_rs2       = idex_q.rs2;
   assign ex_rd        = idex_q.rd;
   assign ex_alu_ctrl  = idex_q.alu_ctrl;
   assign ex_alu_src   = idex_q.alu_src;
   assign ex_reg_write = idex_q.reg_write;
   assign ex_mem_read  = idex_q.mem_read;
   assign ex_mem_write = idex_q.mem_write;

`ifdef ID_STALL_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] flush_cnt_q, flush_cnt_d;

   assign stall_cnt_d = stall_cnt_q + {31'd0, stall};
   assign flush_cnt_d = flush_cnt_q + {31'd0, branch_taken};

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= 32'd0;
         flush_cnt_q <= 32'd0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: expected ID/EX bundles are queued as each instruction enters decode
// and popped after the following clock edge; hazard and branch outputs are checked mid-cycle.
module tb_id_stage;

   localparam logic [31:0] NOP = 32'h00000013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] rs1_data;
      logic [31:0] rs2_data;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [3:0]  alu_ctrl;
      logic        alu_src;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic        chkRd;
      logic        chkRs2;
      logic        chkRs1d;
      logic        chkRs2d;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [31:0] if_pc, if_instr;
   logic        mem_reg_write, mem_mem_read;
   logic [4:0]  mem_rd;
   logic [31:0] mem_alu_result;
   logic        wb_reg_write;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        stall, branch_taken;
   logic [31:0] branch_target;
   logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
   logic [4:0]  ex_rs1, ex_rs2, ex_rd;
   logic [3:0]  ex_alu_ctrl;
   logic        ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write;

   int   numChecks = 0;
   int   numErrors = 0;
   exp_t expQ[$];

   id_stage dut (
      .clk(clk), .rst(rst), .if_pc(if_pc), .if_instr(if_instr),
      .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read), .mem_rd(mem_rd),
      .mem_alu_result(mem_alu_result), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
      .wb_data(wb_data), .stall(stall), .branch_taken(branch_taken),
      .branch_target(branch_target), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
      .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
      .ex_rd(ex_rd), .ex_alu_ctrl(ex_alu_ctrl), .ex_alu_src(ex_alu_src),
      .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      numChecks++;
      assert (obs === expv) else begin
         numErrors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   function automatic exp_t mkBubble();
      exp_t e = '0;
      e.chkRd = 1'b1; e.chkRs2 = 1'b1; e.chkRs1d = 1'b1; e.chkRs2d = 1'b1;
      return e;
   endfunction

   function automatic exp_t mkI(input logic [31:0] pc, input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [31:0] imm, input logic [3:0] ctrl,
                                input logic [31:0] rs1d, input logic chkd);
      exp_t e = '0;
      e.pc = pc; e.rd = rd; e.rs1 = rs1; e.imm = imm; e.alu_ctrl = ctrl;
      e.alu_src = 1'b1; e.reg_write = 1'b1; e.rs1_data = rs1d;
      e.chkRd = 1'b1; e.chkRs1d = chkd;
      return e;
   endfunction

   function automatic exp_t mkNop(input logic [31:0] pc);
      return mkI(pc, 5'd0, 5'd0, 32'd0, 4'd0, 32'd0, 1'b1);
   endfunction

   function automatic exp_t mkR(input logic [31:0] pc, input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [3:0] ctrl,
                                input logic [31:0] d1, input logic [31:0] d2);
      exp_t e = '0;
      e.pc = pc; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.alu_ctrl = ctrl; e.reg_write = 1'b1;
      e.rs1_data = d1; e.rs2_data = d2;
      e.chkRd = 1'b1; e.chkRs2 = 1'b1; e.chkRs1d = 1'b1; e.chkRs2d = 1'b1;
      return e;
   endfunction

   function automatic exp_t mkLoad(input logic [31:0] pc, input logic [4:0] rd, input logic [4:0] rs1,
                                   input logic [31:0] imm, input logic [31:0] d1);
      exp_t e = mkI(pc, rd, rs1, imm, 4'd0, d1, 1'b1);
      e.mem_read = 1'b1;
      return e;
   endfunction

   function automatic exp_t mkStore(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                                    input logic [31:0] imm, input logic [31:0] d1, input logic [31:0] d2);
      exp_t e = '0;
      e.pc = pc; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm; e.alu_src = 1'b1; e.mem_write = 1'b1;
      e.rs1_data = d1; e.rs2_data = d2;
      e.chkRs2 = 1'b1; e.chkRs1d = 1'b1; e.chkRs2d = 1'b1;
      return e;
   endfunction

   task automatic setMem(input logic rw, input logic [4:0] rd, input logic mr, input logic [31:0] res);
      mem_reg_write = rw; mem_rd = rd; mem_mem_read = mr; mem_alu_result = res;
   endtask

   task automatic setWb(input logic w, input logic [4:0] rd, input logic [31:0] data);
      wb_reg_write = w; wb_rd = rd; wb_data = data;
   endtask

   // Fetch presents pc/instr; the bundle for whatever sits in IF/ID this cycle is queued.
   task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] instr, input exp_t e);
      if_pc = pc;
      if_instr = instr;
      expQ.push_back(e);
      #1;
   endtask

   task automatic checkComb(input string tag, input logic expStall, input logic expBt,
                            input logic [31:0] expTarget, input logic chkTarget);
      chk({tag, ".stall"}, {31'd0, stall}, {31'd0, expStall});
      chk({tag, ".branch_taken"}, {31'd0, branch_taken}, {31'd0, expBt});
      if (chkTarget) chk({tag, ".branch_target"}, branch_target, expTarget);
   endtask

   task automatic checkOutput(input string tag);
      exp_t e;
      if (expQ.size() == 0) begin
         numChecks++;
         numErrors++;
         $error("[TB] FAIL %s: scoreboard empty, observed ex_pc %h expected a queued bundle", tag, ex_pc);
      end else begin
         e = expQ.pop_front();
         chk({tag, ".ex_pc"}, ex_pc, e.pc);
         chk({tag, ".ex_imm"}, ex_imm, e.imm);
         chk({tag, ".ex_rs1"}, {27'd0, ex_rs1}, {27'd0, e.rs1});
         chk({tag, ".ex_alu_ctrl"}, {28'd0, ex_alu_ctrl}, {28'd0, e.alu_ctrl});
         chk({tag, ".ctrl"}, {28'd0, ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write},
             {28'd0, e.alu_src, e.reg_write, e.mem_read, e.mem_write});
         if (e.chkRd)   chk({tag, ".ex_rd"}, {27'd0, ex_rd}, {27'd0, e.rd});
         if (e.chkRs2)  chk({tag, ".ex_rs2"}, {27'd0, ex_rs2}, {27'd0, e.rs2});
         if (e.chkRs1d) chk({tag, ".ex_rs1_data"}, ex_rs1_data, e.rs1_data);
         if (e.chkRs2d) chk({tag, ".ex_rs2_data"}, ex_rs2_data, e.rs2_data);
      end
   endtask

   task automatic advance(input string tag);
      @(posedge clk);
      #1;
      checkOutput(tag);
   endtask

   task automatic doReset();
      rst = 1'b1;
      if_pc = 32'd0;
      if_instr = NOP;
      expQ.delete();
      expQ.push_back(mkBubble());
      advance("reset");
      checkComb("reset", 1'b0, 1'b0, 32'd0, 1'b0);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      if_pc = 32'd0;
      if_instr = NOP;
      setMem(1'b0, 5'd0, 1'b0, 32'd0);
      setWb(1'b0, 5'd0, 32'd0);
      doReset();

      // addi x1; addi x2; beq x1,x2,+8 at 0x8: one EX-hazard stall, then taken via EX/MEM forward
      applyStimulus(32'h0, 32'h00500093, mkNop(32'h0));
      checkComb("a0", 1'b0, 1'b0, 32'd0, 1'b0);
      advance("a0_nop");
      applyStimulus(32'h4, 32'h00500113, mkI(32'h0, 5'd1, 5'd0, 32'd5, 4'd0, 32'd0, 1'b1));
      checkComb("a1", 1'b0, 1'b0, 32'd0, 1'b0);
      advance("a1_addi_x1");
      setMem(1'b1, 5'd0, 1'b0, 32'd0);
      applyStimulus(32'h8, 32'h00208463, mkI(32'h4, 5'd2, 5'd0, 32'd5, 4'd0, 32'd0, 1'b1));
      checkComb("a2", 1'b0, 1'b0, 32'd0, 1'b0);
      advance("a2_addi_x2");
      setMem(1'b1, 5'd1, 1'b0, 32'd5);
      setWb(1'b1, 5'd0, 32'd0);
      applyStimulus(32'hC, 32'h00100193, mkBubble());
      checkComb("a3_ex_hazard", 1'b1, 1'b0, 32'd0, 1'b0);
      advance("a3_stall_bubble");
      setMem(1'b1, 5'd2, 1'b0, 32'd5);
      setWb(1'b1, 5'd1, 32'd5);
      applyStimulus(32'hC, 32'h00100193, mkBubble());
      checkComb("a4_beq_taken", 1'b0, 1'b1, 32'h10, 1'b1);
      advance("a4_branch_slot");
      setMem(1'b0, 5'd0, 1'b0, 32'd0);
      setWb(1'b1, 5'd2, 32'd5);
      applyStimulus(32'h10, 32'h00700313, mkNop(32'h0));
      checkComb("a5", 1'b0, 1'b0, 32'd0, 1'b0);
      advance("a5_flushed_nop");

      // lw x4 then addi x5,x4,1: one load-use stall and bubble
      setWb(1'b0, 5'd0, 32'd0);
      doReset();
      applyStimulus(32'h20, 32'h00002203, mkNop(32'h0));
      checkComb("b0", 1'b0, 1'b0, 32'd0, 1'b0);
      advance("b0_nop");
      applyStimulus(32'h24, 32'h00120293, mkLoad(32'h20, 5'd4, 5'd0, 32'd0, 32'd0));
      checkComb("b1", 1'b0, 1'b0, 32'd0, 1'b0);
      advance("b1_lw");
      applyStimulus(32'h28, NOP, mkBubble());
      checkComb("b2_load_use", 1'b1, 1'b0, 32'd0, 1'b0);
      advance("b2_bubble");
      setMem(1'b1, 5'd4, 1'b1, 32'd0);
      applyStimulus(32'h28, NOP, mkI(32'h24, 5'd5, 5'd4, 32'd1, 4'd0, 32'd0, 1'b0));
      checkComb("b3_released", 1'b0, 1'b0, 32'd0, 1'b0);
      advance("b3_addi");

      // Branch with a load in EX/MEM stalls; reset mid-stall leaves no pending hazard
      setMem(1'b0, 5'd0, 1'b0, 32'd0);
      doReset();
      applyStimulus(32'h30, 32'h00208463, mkNop(32'h0));
      advance("e0_nop");
      setMem(1'b1, 5'd2, 1'b1, 32'd0);
      applyStimulus(32'h34, NOP, mkBubble());
      checkComb("e1_mem_load_hazard", 1'b1, 1'b0, 32'd0, 1'b0);
      doReset();
      applyStimulus(32'h0, NOP, mkNop(32'h0));
      checkComb("e2_no_pending", 1'b0, 1'b0, 32'd0, 1'b0);
      advance("e2_nop");

      // x1=3, x2=4 via WB (x2 through same-cycle bypass): beq not taken, bne taken
      setMem(1'b0, 5'd0, 1'b0, 32'd0);
      doReset();
      setWb(1'b1, 5'd1, 32'd3);
      applyStimulus(32'h40, 32'h00208463, mkNop(32'h0));
      advance("c0_nop");
      setWb(1'b1, 5'd2, 32'd4);
      applyStimulus(32'h44, NOP, mkBubble());
      checkComb("c1_beq_not_taken", 1'b0, 1'b0, 32'd0, 1'b0);
      advance("c1_branch_slot");
      setWb(1'b0, 5'd0, 32'd0);
      applyStimulus(32'h48, 32'h00209463, mkNop(32'h44));
      checkComb("c2", 1'b0, 1'b0, 32'd0, 1'b0);
      advance("c2_pc_flow");
      applyStimulus(32'h4C, 32'h00100193, mkBubble());
      checkComb("c3_bne_taken", 1'b0, 1'b1, 32'h50, 1'b1);
      advance("c3_branch_slot");
      applyStimulus(32'h50, NOP, mkNop(32'h0));
      advance("c4_flushed_nop");

      // x0 ignores writes; WB bypass into ID; alu_ctrl funct7 masking; store operands
      doReset();
      setWb(1'b1, 5'd0, 32'hDEADBEEF);
      applyStimulus(32'h60, 32'h000004B3, mkNop(32'h0));
      advance("d0_x0_bypass");
      setWb(1'b0, 5'd0, 32'd0);
      applyStimulus(32'h64, 32'h00038513, mkR(32'h60, 5'd9, 5'd0, 5'd0, 4'd0, 32'd0, 32'd0));
      advance("d1_add_x0");
      setWb(1'b1, 5'd7, 32'h55);
      applyStimulus(32'h68, 32'h401385B3, mkI(32'h64, 5'd10, 5'd7, 32'd0, 4'd0, 32'h55, 1'b1));
      advance("d2_wb_bypass");
      setWb(1'b0, 5'd0, 32'd0);
      applyStimulus(32'h6C, 32'h40000613, mkR(32'h68, 5'd11, 5'd7, 5'd1, 4'b1000, 32'h55, 32'd3));
      advance("d3_sub");
      applyStimulus(32'h70, 32'h4023D693, mkI(32'h6C, 5'd12, 5'd0, 32'h400, 4'b0000, 32'd0, 1'b1));
      advance("d4_addi_bit30");
      applyStimulus(32'h74, 32'h0070A223, mkI(32'h70, 5'd13, 5'd7, 32'h402, 4'b1101, 32'h55, 1'b1));
      advance("d5_srai");
      applyStimulus(32'h78, NOP, mkStore(32'h74, 5'd1, 5'd7, 32'd4, 32'd3, 32'h55));
      advance("d6_sw");

      $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
      $finish;
   end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
Decode stage of the 5-stage RV32I pipeline, directly downstream of the fetch stage.
- Contains the IF/ID latch, the 32-entry register file, the decoder, the load-use/branch hazard unit, and the beq/bne resolver.
- Drives `stall`, `branch_taken` and `branch_target` back to fetch.
- Presents a registered ID/EX bundle to execute.

Parameters:
- NOP_INSTR, 32'h00000013, instruction loaded into IF/ID on reset or flush
- RESET_PC, 32'h00000000, PC value latched into IF/ID on reset or flush

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- if_pc  in  32  PC of the instruction fetched this cycle
- if_instr  in  32  instruction fetched this cycle
- mem_reg_write  in  1  EX/MEM instruction writes a register
- mem_mem_read  in  1  EX/MEM instruction is a load
- mem_rd  in  5  EX/MEM destination register
- mem_alu_result  in  32  EX/MEM ALU result, forwarded to the branch comparator
- wb_reg_write  in  1  writeback enable
- wb_rd  in  5  writeback destination register
- wb_data  in  32  writeback data
- stall  out  1  combinational; fetch holds PC, IF/ID holds
- branch_taken  out  1  combinational; fetch redirects
- branch_target  out  32  combinational; id_pc + B-immediate
- ex_pc  out  32  ID/EX PC
- ex_rs1_data  out  32  ID/EX operand 1
- ex_rs2_data  out  32  ID/EX operand 2
- ex_imm  out  32  ID/EX sign-extended immediate
- ex_rs1  out  5  ID/EX source register 1
- ex_rs2  out  5  ID/EX source register 2
- ex_rd  out  5  ID/EX destination register
- ex_alu_ctrl  out  4  {funct7[5], funct3}
- ex_alu_src  out  1  1 selects the immediate
- ex_reg_write  out  1  ID/EX writes a register
- ex_mem_read  out  1  ID/EX is a load
- ex_mem_write  out  1  ID/EX is a store

Behaviour:
- Clocking: one clock `clk`; reset `rst` is synchronous and active-high.
- IF/ID latch:
  - On `rst` or `branch_taken`: load NOP_INSTR / RESET_PC.
  - Else on `stall`: hold.
  - Else: capture if_instr / if_pc.
- Register file:
  - 32x32. Written at posedge when wb_reg_write and wb_rd != 0.
  - x0 always reads 0.
  - Same-cycle write-read bypass: a read of wb_rd returns wb_data.
  - Contents are not cleared by `rst`.
- Decode:
  - R (0x33): alu_src=0, reg_write=1.
  - I-ALU (0x13): alu_src=1, reg_write=1, I-immediate. funct7[5] is passed only for funct3=101; otherwise 0.
  - LOAD (0x03): alu_src=1, reg_write=1, mem_read=1, alu_ctrl=0000.
  - STORE (0x23): alu_src=1, mem_write=1, S-immediate, alu_ctrl=0000.
  - BRANCH (0x63): resolved here; all ex_* controls are 0.
  - Any other opcode: decoded as a bubble.
  - Register use: rs1 is used by R/I/L/S/B; rs2 is used by R/S/B only.
- Hazard unit (stall combinational; any condition asserts it):
  - (a) Load-use: ex_mem_read, ex_rd != 0, and ex_rd equals a used rs.
  - (b) Branch in ID with ex_reg_write, ex_rd != 0, and ex_rd equals rs1 or rs2.
  - (c) Branch in ID with mem_mem_read, mem_rd != 0, and mem_rd equals rs1 or rs2.
- Branch comparator:
  - Operand source priority: mem_alu_result when mem_reg_write, mem_rd matches and mem_rd != 0; else register-file read (including WB bypass).
  - beq (funct3 000) takes on equal; bne (001) takes on not-equal; other funct3 values are never taken.
  - branch_taken = branch & condition & !stall. stall and branch_taken are never both 1.
- ID/EX register:
  - On `rst`: every ex_* output is 0.
  - On stall: insert a bubble (all controls 0, ex_rd = 0; data fields don't-care but driven 0).
  - Otherwise: load decoded values.
  - A taken branch's own ID/EX slot is a bubble.
  - Latency: ID/EX outputs are valid 1 cycle after the instruction occupies IF/ID.
- After reset, `stall` and `branch_taken` are 0 while IF/ID holds the NOP.
- Reset asserted mid-stall or mid-branch: the next cycle shows the NOP in IF/ID and a zeroed ID/EX; no pending hazard persists.

Optional Feature:
- Macro: ID_STALL_CNT_EN.
- When defined, adds outputs `stall_cnt` (32) and `flush_cnt` (32).
  - `stall_cnt` increments each cycle stall=1.
  - `flush_cnt` increments each cycle branch_taken=1.
  - Both wrap at 2^32 and are cleared by `rst`.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset → instr 32'h13 in IF/ID; all ex_* = 0; stall = 0; branch_taken = 0.
- Forwarding/branch taken:
  - Stimulus: addi x1,x0,5 (0x00500093); addi x2,x0,5 (0x00500113); beq x1,x2,+8 (0x00208463) at PC 0x8.
  - Required response: stall=1 for exactly 1 cycle, then branch_taken=1 with branch_target=0x10, which uses EX/MEM forwarding of x2=5.
  - The next IF/ID holds the NOP.
- Load-use stall:
  - Stimulus: lw x4,0(x0) (0x00002203) followed by addi x5,x4,1 (0x00120293).
  - Required response: stall=1 for 1 cycle; ID/EX bubble (ex_reg_write=0, ex_rd=0); then the addi issues with ex_rs1=4 and ex_imm=1.
- Branch not taken:
  - Stimulus: x1=3, x2=4 written via WB, then beq x1,x2 issued with no EX/MEM match.
  - Required response: branch_taken=0; PC flow is uninterrupted.
- bne taken:
  - Stimulus: bne x1,x2,+8 (0x00209463) with x1=3, x2=4.
  - Required response: branch_taken=1 with branch_target = id_pc+8.
- x0 and WB bypass:
  - Stimulus: wb_rd=0 with wb_data=0xDEADBEEF, then a read of x0.
  - Required response: x0 reads 0.
  - Stimulus: wb_rd=7 and wb_data=0x55 in the same cycle an instruction reads x7 in ID.
  - Required response: the instruction latches ex_rs1_data=0x55.
